cache_l1_assoc: RTL and testbench

- Parametrised N-way set-associative L1 data cache, single-word lines, write-through, no write-allocate.
- Sits between the core load/store port and the memory/L2 port. Both sides use valid/ready handshakes.
- Next generation of the direct-mapped L1: adds configurable ways/sets, miss handling with refill FSM, round-robin replacement, flush and a reset.

---
 rtl/cache_l1_assoc.sv | 206 ++++++++++++++++++++
 tb/tb_cache_l1_assoc.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_l1_assoc.sv
// N-way set-associative, write-through, no-write-allocate L1 data cache with single-word lines.
// Optional hit/miss counters are enabled by defining CACHE_L1_STATS_EN.
module cache_l1_assoc #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int SETS   = 256,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_L1_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, WRITE_REQ} state_t;

  state_t            state;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;

  logic [SETS-1:0]   valid_q  [WAYS];
  logic [WAY_W-1:0]  rr_q     [SETS];
  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [DATA_W-1:0] data_mem [WAYS][SETS];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [DATA_W-1:0] hit_data;
  logic [WAY_W-1:0]  victim;
  logic              victim_inv;
  logic              flush_fire;
  logic              fill_fire;

  assign req_idx    = req_addr[OFF_W +: IDX_W];
  assign req_tag    = req_addr[ADDR_W-1 -: TAG_W];
  assign flush_fire = (state == IDLE) && flush;
  assign fill_fire  = (state == REFILL_WAIT) && mem_resp_valid;

  // Both ports: a transfer happens on a rising edge where valid and ready are both high;
  // the initiator holds valid and its payload steady until that edge.
  assign cpu_req_ready = (state == IDLE) && !flush && !rst;

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
        hit      = 1'b1;
        hit_way  = WAY_W'(w);
        hit_data = data_mem[w][req_idx];
      end
    end
  end

  // Descending scan so the lowest-numbered invalid way wins; RR pointer only if the set is full.
  always_comb begin
    victim     = rr_q[req_idx];
    victim_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][req_idx]) begin
        victim     = WAY_W'(w);
        victim_inv = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      req_addr       <= '0;
      req_we         <= 1'b0;
      req_wdata      <= '0;
      cpu_resp_valid <= 1'b0;
      cpu_rdata      <= '0;
      mem_req_valid  <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      cpu_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush && cpu_req_valid) begin
            req_addr  <= cpu_addr;
            req_we    <= cpu_we;
            req_wdata <= cpu_wdata;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (req_we) begin
            mem_req_valid <= 1'b1;
            mem_we        <= 1'b1;
            mem_addr      <= req_addr & ~OFF_MASK;
            mem_wdata     <= req_wdata;
            state         <= WRITE_REQ;
          end else if (hit) begin
            cpu_resp_valid <= 1'b1;
            cpu_rdata      <= hit_data;
            state          <= IDLE;
          end else begin
            mem_req_valid <= 1'b1;
            mem_we        <= 1'b0;
            mem_addr      <= req_addr & ~OFF_MASK;
            state         <= REFILL_REQ;
          end
        end
        REFILL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= REFILL_WAIT;
          end
        end
        REFILL_WAIT: begin
          if (mem_resp_valid) begin
            cpu_resp_valid <= 1'b1;
            cpu_rdata      <= mem_rdata;
            state          <= IDLE;
          end
        end
        WRITE_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid  <= 1'b0;
            mem_we         <= 1'b0;
            cpu_resp_valid <= 1'b1;
            cpu_rdata      <= '0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (flush_fire) begin
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (fill_fire) begin
      valid_q[victim][req_idx] <= 1'b1;
      if (!victim_inv) begin
        rr_q[req_idx] <= (victim == WAY_W'(WAYS - 1)) ? '0 : victim + WAY_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state == LOOKUP) && req_we && hit) begin
      data_mem[hit_way][req_idx] <= req_wdata;
    end
    if (fill_fire) begin
      data_mem[victim][req_idx] <= mem_rdata;
      tag_mem[victim][req_idx]  <= req_tag;
    end
  end

`ifdef CACHE_L1_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (flush_fire) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_l1_assoc.sv
// Bench for cache_l1_assoc (default parameters, 2 ways): vector table plus hand-written
// sequences for stall, flush and reset; a behavioural memory answers the mem port.
module tb_cache_l1_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_we;
  logic [63:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic        cpu_resp_valid;
  logic [63:0] cpu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_rdata;

  cache_l1_assoc dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_rdata      (cpu_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mem_model [logic [63:0]];

  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          stall_left = 0;
  int          resp_delay = 1;
  int          pend_cnt = 0;
  logic [63:0] pend_data;
  logic [63:0] last_rd_addr = '0;
  logic [63:0] last_wr_addr = '0;
  logic [63:0] last_wr_data = '0;
  bit          prev_stalled = 1'b0;
  logic [63:0] prev_addr = '0;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
    int          reads;
    int          writes;
    bit          lat;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_read(input logic [63:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[31:0] ^ 32'h5A5A_5A5A, a[31:0]};
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_rdata      = pend_data;
        end
      end
      if (prev_stalled && !rst) begin
        check("stall_valid_held", {63'd0, mem_req_valid}, 64'd1);
        check("stall_addr_held", mem_addr, prev_addr);
        check("stall_core_ready", {63'd0, cpu_req_ready}, 64'd0);
      end
      if (mem_req_valid && stall_left > 0) begin
        mem_req_ready = 1'b0;
        stall_left--;
      end else begin
        mem_req_ready = 1'b1;
      end
      prev_stalled = !rst && mem_req_valid && !mem_req_ready;
      prev_addr    = mem_addr;
      if (!rst && mem_req_valid && mem_req_ready) begin
        if (mem_we) begin
          wr_cnt++;
          last_wr_addr        = mem_addr;
          last_wr_data        = mem_wdata;
          mem_model[mem_addr] = mem_wdata;
        end else begin
          rd_cnt++;
          last_rd_addr = mem_addr;
          pend_data    = mem_read(mem_addr);
          pend_cnt     = resp_delay;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && cpu_resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp actual=%h required=no_response", cpu_rdata);
        end else begin
          check("resp_rdata", cpu_rdata, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] exp_rdata, input int exp_reads, input int exp_writes,
                        input bit chk_lat);
    int rd0 = rd_cnt;
    int wr0 = wr_cnt;
    int lat = 0;
    int guard = 0;
    bit timed_out = 1'b0;
    while (!cpu_req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    cpu_req_valid = 1'b1;
    cpu_we        = we;
    cpu_addr      = addr;
    cpu_wdata     = wdata;
    exp_q.push_back(exp_rdata);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    lat = 1;
    while (!cpu_resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    timed_out = (lat >= 200);
    check("resp_timeout", {63'd0, timed_out}, 64'd0);
    if (timed_out && exp_q.size() > 0) void'(exp_q.pop_back());
    check("mem_reads", 64'(rd_cnt - rd0), 64'(exp_reads));
    check("mem_writes", 64'(wr_cnt - wr0), 64'(exp_writes));
    if (chk_lat) check("hit_latency", 64'(lat), 64'd2);
    if (exp_reads > 0) check("rd_addr", last_rd_addr, addr & ~64'h7);
    if (exp_writes > 0) begin
      check("wr_addr", last_wr_addr, addr & ~64'h7);
      check("wr_data", last_wr_data, wdata);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int rd0;
    int g;
    rst           = 1'b1;
    flush         = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_we        = 1'b0;
    cpu_addr      = '0;
    cpu_wdata     = '0;

    mem_model[64'h1000] = 64'hAAAA_0001;
    mem_model[64'h2000] = 64'hBBBB_0002;
    mem_model[64'h3000] = 64'hCCCC_0003;
    mem_model[64'h4000] = 64'hDDDD_0004;
    mem_model[64'h1008] = 64'h1111_2222_3333_4444;
    mem_model[64'h7000] = {$urandom, $urandom};

    // 0x1000..0x4000 share set 0; round-robin pointer evolution is traced in the expectations.
    tbl[0]  = '{1'b0, 64'h1000, 64'h0,  64'hAAAA_0001, 1, 0, 1'b0};
    tbl[1]  = '{1'b0, 64'h1000, 64'h0,  64'hAAAA_0001, 0, 0, 1'b1};
    tbl[2]  = '{1'b0, 64'h2000, 64'h0,  64'hBBBB_0002, 1, 0, 1'b0};
    tbl[3]  = '{1'b0, 64'h3000, 64'h0,  64'hCCCC_0003, 1, 0, 1'b0};
    tbl[4]  = '{1'b0, 64'h2000, 64'h0,  64'hBBBB_0002, 0, 0, 1'b1};
    tbl[5]  = '{1'b0, 64'h1000, 64'h0,  64'hAAAA_0001, 1, 0, 1'b0};
    tbl[6]  = '{1'b0, 64'h2000, 64'h0,  64'hBBBB_0002, 1, 0, 1'b0};
    tbl[7]  = '{1'b0, 64'h1000, 64'h0,  64'hAAAA_0001, 0, 0, 1'b1};
    tbl[8]  = '{1'b1, 64'h2000, 64'h55, 64'h0,         0, 1, 1'b0};
    tbl[9]  = '{1'b0, 64'h2000, 64'h0,  64'h55,        0, 0, 1'b1};
    tbl[10] = '{1'b1, 64'h4000, 64'h77, 64'h0,         0, 1, 1'b0};
    tbl[11] = '{1'b0, 64'h4000, 64'h0,  64'h77,        1, 0, 1'b0};
    tbl[12] = '{1'b0, 64'h2000, 64'h0,  64'h55,        0, 0, 1'b1};
    tbl[13] = '{1'b0, 64'h1008, 64'h0,  64'h1111_2222_3333_4444, 1, 0, 1'b0};
    tbl[14] = '{1'b0, 64'h100C, 64'h0,  64'h1111_2222_3333_4444, 0, 0, 1'b1};
    tbl[15] = '{1'b1, 64'h100C, 64'h99, 64'h0,         0, 1, 1'b0};
    tbl[16] = '{1'b0, 64'h1008, 64'h0,  64'h99,        0, 0, 1'b1};

    repeat (2) @(negedge clk);
    check("rst_cpu_req_ready", {63'd0, cpu_req_ready}, 64'd0);
    check("rst_cpu_resp_valid", {63'd0, cpu_resp_valid}, 64'd0);
    check("rst_cpu_rdata", cpu_rdata, 64'd0);
    check("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {63'd0, cpu_req_ready}, 64'd1);

    for (int i = 0; i < 17; i++) begin
      resp_delay = (i == 0) ? 3 : int'($urandom_range(1, 4));
      do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp,
             tbl[i].reads, tbl[i].writes, tbl[i].lat);
    end

    // memory holds off the refill request for five cycles
    resp_delay = 2;
    stall_left = 5;
    do_req(1'b0, 64'h5000, 64'h0, mem_read(64'h5000), 1, 0, 1'b0);
    check("stall_consumed", 64'(stall_left), 64'd0);

    // flush in IDLE invalidates, and wins over a simultaneous request
    do_req(1'b0, 64'h6000, 64'h0, mem_read(64'h6000), 1, 0, 1'b0);
    do_req(1'b0, 64'h6000, 64'h0, mem_read(64'h6000), 0, 0, 1'b1);
    flush         = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_we        = 1'b0;
    cpu_addr      = 64'h6000;
    #1;
    check("flush_blocks_ready", {63'd0, cpu_req_ready}, 64'd0);
    @(negedge clk);
    flush         = 1'b0;
    cpu_req_valid = 1'b0;
    #1;
    check("flush_req_not_taken", {63'd0, cpu_req_ready}, 64'd1);
    repeat (3) @(negedge clk);
    do_req(1'b0, 64'h6000, 64'h0, mem_read(64'h6000), 1, 0, 1'b0);
    do_req(1'b0, 64'h2000, 64'h0, mem_read(64'h2000), 1, 0, 1'b0);

    // flush while waiting for refill data has no effect
    resp_delay = 5;
    rd0 = rd_cnt;
    fork
      do_req(1'b0, 64'h7000, 64'h0, mem_read(64'h7000), 1, 0, 1'b0);
      begin
        g = 0;
        while (rd_cnt == rd0 && g < 50) begin
          @(negedge clk);
          g++;
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    do_req(1'b0, 64'h7000, 64'h0, mem_read(64'h7000), 0, 0, 1'b1);

    // reset during REFILL_WAIT; the late memory response must be ignored
    resp_delay    = 6;
    rd0           = rd_cnt;
    cpu_req_valid = 1'b1;
    cpu_we        = 1'b0;
    cpu_addr      = 64'h8000;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    g = 0;
    while (rd_cnt == rd0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("rstseq_read_issued", 64'(rd_cnt - rd0), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_cpu_req_ready", {63'd0, cpu_req_ready}, 64'd0);
    check("midrst_cpu_resp_valid", {63'd0, cpu_resp_valid}, 64'd0);
    check("midrst_cpu_rdata", cpu_rdata, 64'd0);
    check("midrst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("midrst_mem_we", {63'd0, mem_we}, 64'd0);
    check("midrst_mem_addr", mem_addr, 64'd0);
    check("midrst_mem_wdata", mem_wdata, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("ready_after_midrst", {63'd0, cpu_req_ready}, 64'd1);
    do_req(1'b0, 64'h8000, 64'h0, mem_read(64'h8000), 1, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
